// File: rtl/priority_irq_ctrl_pkg.sv
//----------------------------------------------------------------------------
// Module : priority_irq_ctrl_pkg
// Brief  : Shared types, sizes and rotation helpers for priority_irq_ctrl.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package priority_irq_ctrl_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SVC  = 2'd2
  } state_t;

  // Rotate right: result[i] = v[(i + s) mod N_REQ].
  function automatic logic [N_REQ-1:0] rotr(input logic [N_REQ-1:0] v,
                                            input logic [IDX_W-1:0] s);
    logic [2*N_REQ-1:0] d;
    d = {v, v} >> s;
    return d[N_REQ-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] bitrev(input logic [N_REQ-1:0] v);
    logic [N_REQ-1:0] r;
    for (int i = 0; i < N_REQ; i++) r[i] = v[N_REQ-1-i];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/priority_irq_ctrl_prio_enc8.sv
//----------------------------------------------------------------------------
// Module : prio_enc8
// Brief  : 8-to-3 active-high priority encoder, highest set bit wins.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module prio_enc8
  import priority_irq_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |in;
    for (int i = 0; i < N_REQ; i++) begin
      if (in[i]) idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/priority_irq_ctrl.sv
//----------------------------------------------------------------------------
// Module : priority_irq_ctrl
// Brief  : 8-source falling-edge interrupt controller with irq/ack/eoi
//          handshake. Optional macro ROUND_ROBIN_EN enables rotating priority.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module priority_irq_ctrl
  import priority_irq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_n,
  input  logic             en_n,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [IDX_W-1:0] vec,
  output logic             gs_n,
  output logic             busy,
  output logic [N_REQ-1:0] pending
);

  state_t           state;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] cap;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] avail;
  logic [N_REQ-1:0] enc_in;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;
  logic [IDX_W-1:0] grant;

  assign cap   = req_q & ~req_n & {N_REQ{~en_n}};
  assign clr   = (state == PEND && ack) ? ({{(N_REQ-1){1'b0}}, 1'b1} << vec) : '0;
  assign avail = pending & ~mask;

`ifdef ROUND_ROBIN_EN
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_REQ - 1);
  logic [IDX_W-1:0] rr_ptr;

  // rr_ptr sits at rotated bit 0 and is served first; the lowest set rotated
  // bit wins, which the reversal maps onto the highest-bit encoder.
  assign enc_in = bitrev(rotr(avail, rr_ptr));
  assign grant  = (IDX_MAX - enc_idx) + rr_ptr;
`else
  assign enc_in = avail;
  assign grant  = enc_idx;
`endif

  prio_enc8 u_enc (
    .in    (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '1;
      pending <= '0;
      gs_n    <= 1'b1;
      state   <= IDLE;
      irq     <= 1'b0;
      vec     <= '0;
      busy    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_ptr  <= '0;
`endif
    end else begin
      req_q   <= req_n;
      // A fresh capture on the bit being acked survives the clear.
      pending <= (pending & ~clr) | cap;
      gs_n    <= ~|avail;
      case (state)
        IDLE: begin
          if (!en_n && enc_valid) begin
            vec   <= grant;
            irq   <= 1'b1;
            state <= PEND;
          end
        end
        PEND: begin
          if (ack) begin
            irq   <= 1'b0;
            busy  <= 1'b1;
            state <= SVC;
`ifdef ROUND_ROBIN_EN
            rr_ptr <= vec + 1'b1;
`endif
          end else if (en_n) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        SVC: begin
          if (eoi) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
